// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: physical/index widths, undo-log entry layout and walk states.
// pd_new is carried in the entry only when UNDO_LOG_FREE_NEW_EN is defined.
package ooo_pkg;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_PHYS_REGS = 64;
    localparam int PHYS_W            = $clog2(DEFAULT_PHYS_REGS);
    localparam int IDX_W             = $clog2(DEFAULT_DEPTH);
    localparam int ARCH_W            = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_t;

    typedef struct packed {
        logic              uses_rd;
        logic [ARCH_W-1:0] rd_arch;
        logic [PHYS_W-1:0] pd_old;
`ifdef UNDO_LOG_FREE_NEW_EN
        logic [PHYS_W-1:0] pd_new;
`endif
    } undo_entry_t;
endpackage

// File: rtl/rename_undo_log_if.sv
// Port bundle between the rename/retire/redirect logic (master) and the undo log (slave).
// Master drives rename, commit and redirect controls; slave returns frees, RAT restores and busy.
interface rename_undo_log_if;
    logic                        rename_valid;
    logic                        rename_uses_rd;
    logic [ooo_pkg::ARCH_W-1:0]  rename_rd_arch;
    logic [ooo_pkg::PHYS_W-1:0]  rename_pd_old;
    logic [ooo_pkg::PHYS_W-1:0]  rename_pd_new;
    logic                        rename_ready;
    logic [ooo_pkg::IDX_W-1:0]   alloc_idx;
    logic                        commit_valid;
    logic                        free_valid;
    logic [ooo_pkg::PHYS_W-1:0]  free_pd;
    logic                        mispredict_valid;
    logic [ooo_pkg::IDX_W-1:0]   mispredict_idx;
    logic                        flush_valid;
    logic                        recover_valid;
    logic [ooo_pkg::ARCH_W-1:0]  recover_rd_arch;
    logic [ooo_pkg::PHYS_W-1:0]  recover_pd;
    logic                        recover_free_valid;
    logic [ooo_pkg::PHYS_W-1:0]  recover_free_pd;
    logic                        busy;

    modport master (
        output rename_valid, rename_uses_rd, rename_rd_arch, rename_pd_old, rename_pd_new,
        output commit_valid, mispredict_valid, mispredict_idx, flush_valid,
        input  rename_ready, alloc_idx, free_valid, free_pd,
        input  recover_valid, recover_rd_arch, recover_pd,
        input  recover_free_valid, recover_free_pd, busy
    );

    modport slave (
        input  rename_valid, rename_uses_rd, rename_rd_arch, rename_pd_old, rename_pd_new,
        input  commit_valid, mispredict_valid, mispredict_idx, flush_valid,
        output rename_ready, alloc_idx, free_valid, free_pd,
        output recover_valid, recover_rd_arch, recover_pd,
        output recover_free_valid, recover_free_pd, busy
    );
endinterface

// File: rtl/rename_undo_log.sv
// Rename undo log: commit frees the oldest pd_old; a mispredict walks youngest-first restoring the RAT, one entry per cycle.
// Outputs are combinational in the same cycle; rename_ready drops when full, walking or redirected. UNDO_LOG_FREE_NEW_EN also returns squashed pd_new.
module rename_undo_log
    import ooo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PHYS_REGS = DEFAULT_PHYS_REGS
) (
    input  logic             clk,
    input  logic             rst_n,
    rename_undo_log_if.slave u
);
    localparam int CNT_W = IDX_W + 1;
    localparam int PW    = $clog2(PHYS_REGS);
    localparam logic [PW-1:0] PD_ZERO = '0;

    undo_entry_t      mem [DEPTH];
    undo_entry_t      wr_entry;
    undo_entry_t      e_walk;
    walk_state_t      state;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] target;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] tail_m1;
    logic [IDX_W-1:0] tail_m2;
    logic             live;
    logic             rename_fire;
    logic             commit_fire;
    logic             walk_pop;
    logic             walk_done;
    logic             mis_fire;

    // Reset and flush both silence every output strobe in the cycle they are seen.
    assign live        = rst_n && !u.flush_valid;
    assign tail_m1     = tail - IDX_W'(1);
    assign tail_m2     = tail - IDX_W'(2);
    assign e_walk      = mem[tail_m1];

    assign u.rename_ready = (state == ST_IDLE) && (count < CNT_W'(DEPTH))
                          && !u.mispredict_valid && !u.flush_valid;
    assign u.alloc_idx    = tail;
    assign u.busy         = (state == ST_WALK);

    assign rename_fire = u.rename_valid && u.rename_ready;
    assign walk_pop    = live && (state == ST_WALK) && (count != '0);
    // A lone remaining entry also ends the walk, so a bad target can never underflow the log.
    assign walk_done   = (tail_m2 == target) || (count == CNT_W'(1));
    assign commit_fire = live && u.commit_valid && (count != '0)
                       && !(walk_pop && (count == CNT_W'(1)));
    assign mis_fire    = live && (state == ST_IDLE) && u.mispredict_valid;

    assign u.free_valid      = commit_fire && mem[head].uses_rd;
    assign u.free_pd         = commit_fire ? mem[head].pd_old : PD_ZERO;
    assign u.recover_valid   = walk_pop && e_walk.uses_rd;
    assign u.recover_rd_arch = walk_pop ? e_walk.rd_arch : '0;
    assign u.recover_pd      = walk_pop ? e_walk.pd_old : PD_ZERO;

`ifdef UNDO_LOG_FREE_NEW_EN
    assign u.recover_free_valid = walk_pop && e_walk.uses_rd;
    assign u.recover_free_pd    = walk_pop ? e_walk.pd_new : PD_ZERO;
`else
    logic unused_pd_new;
    assign unused_pd_new        = ^u.rename_pd_new;
    assign u.recover_free_valid = 1'b0;
    assign u.recover_free_pd    = PD_ZERO;
`endif

    always_comb begin
        wr_entry         = '0;
        wr_entry.uses_rd = u.rename_uses_rd;
        wr_entry.rd_arch = u.rename_rd_arch;
        wr_entry.pd_old  = u.rename_pd_old;
`ifdef UNDO_LOG_FREE_NEW_EN
        wr_entry.pd_new  = u.rename_pd_new;
`endif
    end

    always_ff @(posedge clk) begin
        if (rename_fire) begin
            mem[tail] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            target <= '0;
        end else if (u.flush_valid) begin
            state <= ST_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (commit_fire) begin
                head <= head + IDX_W'(1);
            end
            count <= count + CNT_W'(rename_fire) - CNT_W'(commit_fire) - CNT_W'(walk_pop);
            case (state)
                ST_IDLE: begin
                    if (mis_fire) begin
                        target <= u.mispredict_idx;
                        if (u.mispredict_idx != tail_m1) begin
                            state <= ST_WALK;
                        end
                    end else if (rename_fire) begin
                        tail <= tail + IDX_W'(1);
                    end
                end
                ST_WALK: begin
                    if (walk_pop) begin
                        tail <= tail_m1;
                        if (walk_done) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
